// File: rtl/plru_state_array_if.sv
// plru_state_array_if: read/write/init bus between the cache PLRU logic and the per-set state array.
interface plru_state_array_if #(parameter int NUM_SETS = 16);
    localparam int SET_IDX_W = $clog2(NUM_SETS);
    logic                 rd_en;
    logic [SET_IDX_W-1:0] rd_set;
    logic [2:0]           rd_data;
    logic                 rd_valid;
    logic                 wr_en;
    logic [SET_IDX_W-1:0] wr_set;
    logic [2:0]           wr_data;
    logic                 init_busy;
    modport master (output rd_en, rd_set, wr_en, wr_set, wr_data, input rd_data, rd_valid, init_busy);
    modport slave  (input rd_en, rd_set, wr_en, wr_set, wr_data, output rd_data, rd_valid, init_busy);
endinterface

// File: rtl/plru_state_array.sv
// plru_state_array: per-set 3-bit tree-PLRU state store with post-reset clear sweep and hold coherence.
// Define PLRU_BYPASS_EN for write-first same-set read/write forwarding; default build is read-first.
module plru_state_array #(
    parameter int NUM_SETS = 16
) (
    input logic clk,
    input logic rst_n,
    plru_state_array_if.slave bus
);
    localparam int SET_IDX_W = $clog2(NUM_SETS);
    localparam logic [SET_IDX_W:0] LAST = (SET_IDX_W+1)'(NUM_SETS - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t               state, state_nx;
    logic [SET_IDX_W:0]   cnt, cnt_nx;
    logic [2:0]           entry [NUM_SETS];
    logic [SET_IDX_W-1:0] held_set;
    logic [2:0]           rd_data_q, rd_word;
    logic                 rd_valid_q, run, hold_hit;

    assign run      = state == RUN;
    assign hold_hit = bus.wr_en && bus.wr_set == held_set;

`ifdef PLRU_BYPASS_EN
    assign rd_word = (bus.wr_en && bus.wr_set == bus.rd_set) ? bus.wr_data : entry[bus.rd_set];
`else
    assign rd_word = entry[bus.rd_set];
`endif

    always_comb begin
        state_nx = (state == INIT && cnt == LAST) ? RUN : state;
        cnt_nx   = (state == INIT) ? cnt + 1'b1 : cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= INIT;
            cnt        <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 3'b000;
            held_set   <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rd_valid_q <= run && bus.rd_en;
            if (run && bus.rd_en) begin
                held_set  <= bus.rd_set;
                rd_data_q <= rd_word;
            end else if (run && hold_hit) begin
                rd_data_q <= bus.wr_data;
            end
        end
    end

    // The sweep owns the array until RUN, so cache writes during INIT are dropped.
    always_ff @(posedge clk) begin
        if (!run)
            entry[cnt[SET_IDX_W-1:0]] <= 3'b000;
        else if (rst_n && bus.wr_en)
            entry[bus.wr_set] <= bus.wr_data;
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.init_busy = !run;
endmodule

// File: tb/tb_plru_state_array.sv
// tb_plru_state_array: directed self-checking bench for the PLRU state array.
module tb_plru_state_array;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [2:0] mdl [16];

`ifdef PLRU_BYPASS_EN
    localparam logic [2:0] COLLIDE_EXP = 3'b111;
`else
    localparam logic [2:0] COLLIDE_EXP = 3'b010;
`endif

    plru_state_array_if #(.NUM_SETS(16)) bus ();
    plru_state_array #(.NUM_SETS(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en = 1'b0;
        bus.rd_set = '0;
        bus.wr_en = 1'b0;
        bus.wr_set = '0;
        bus.wr_data = '0;
    endtask

    task automatic test_reset();
        int busy_cycles;
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if (bus.init_busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b valid=%b data=%b, required busy=1 valid=0 data=000", bus.init_busy, bus.rd_valid, bus.rd_data);
        end
        rst_n = 1'b1;
        busy_cycles = 0;
        while (bus.init_busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            step();
        end
        n_checks++;
        if (busy_cycles != 16) begin
            n_fail++;
            $display("FAIL sweep_length: busy for %0d cycles, required 16", busy_cycles);
        end
        for (int s = 0; s < 16; s++) begin
            bus.rd_en = 1'b1;
            bus.rd_set = 4'(s);
            step();
            n_checks++;
            if (bus.rd_data !== 3'b000 || bus.rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_clear set %0d: data=%b valid=%b, required 000 valid=1", s, bus.rd_data, bus.rd_valid);
            end
        end
        idle();
        step();
    endtask

    task automatic test_basic_rw();
        bus.wr_en = 1'b1; bus.wr_set = 4'd5; bus.wr_data = 3'b101;
        step();
        idle();
        bus.rd_en = 1'b1; bus.rd_set = 4'd5;
        step();
        n_checks++;
        if (bus.rd_data !== 3'b101 || bus.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_read5: data=%b valid=%b, required 101 valid=1", bus.rd_data, bus.rd_valid);
        end
        bus.rd_set = 4'd6;
        step();
        n_checks++;
        if (bus.rd_data !== 3'b000 || bus.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_read6: data=%b valid=%b, required 000 valid=1", bus.rd_data, bus.rd_valid);
        end
        idle();
        step();
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_hold: data=%b valid=%b, required 000 valid=0", bus.rd_data, bus.rd_valid);
        end
    endtask

    task automatic test_collision();
        bus.wr_en = 1'b1; bus.wr_set = 4'd3; bus.wr_data = 3'b010;
        step();
        bus.rd_en = 1'b1; bus.rd_set = 4'd3; bus.wr_data = 3'b111;
        step();
        n_checks++;
        if (bus.rd_data !== COLLIDE_EXP || bus.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL collision: data=%b valid=%b, required %b valid=1", bus.rd_data, bus.rd_valid, COLLIDE_EXP);
        end
        bus.wr_en = 1'b0;
        step();
        n_checks++;
        if (bus.rd_data !== 3'b111) begin
            n_fail++;
            $display("FAIL collision_commit: data=%b, required 111", bus.rd_data);
        end
        idle();
        step();
    endtask

    task automatic test_hold_coherence();
        bus.wr_en = 1'b1; bus.wr_set = 4'd9; bus.wr_data = 3'b001;
        step();
        idle();
        bus.rd_en = 1'b1; bus.rd_set = 4'd9;
        step();
        n_checks++;
        if (bus.rd_data !== 3'b001 || bus.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_read9: data=%b valid=%b, required 001 valid=1", bus.rd_data, bus.rd_valid);
        end
        idle();
        bus.wr_en = 1'b1; bus.wr_set = 4'd9; bus.wr_data = 3'b110;
        step();
        n_checks++;
        if (bus.rd_data !== 3'b110 || bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_update: data=%b valid=%b, required 110 valid=0", bus.rd_data, bus.rd_valid);
        end
        bus.wr_set = 4'd8; bus.wr_data = 3'b011;
        step();
        n_checks++;
        if (bus.rd_data !== 3'b110) begin
            n_fail++;
            $display("FAIL hold_other_set: data=%b, required 110", bus.rd_data);
        end
        idle();
        step();
    endtask

    task automatic test_reset_mid_sweep();
        int busy_cycles;
        int leaks;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (7) step();
        n_checks++;
        if (bus.init_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sweep_busy: busy=%b, required 1", bus.init_busy);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.rd_en = 1'b1; bus.rd_set = 4'd0;
        bus.wr_en = 1'b1; bus.wr_set = 4'd0; bus.wr_data = 3'b111;
        busy_cycles = 0;
        leaks = 0;
        while (bus.init_busy === 1'b1 && busy_cycles < 40) begin
            if (bus.rd_valid !== 1'b0) leaks++;
            busy_cycles++;
            step();
        end
        n_checks++;
        if (busy_cycles != 16) begin
            n_fail++;
            $display("FAIL resweep_length: busy for %0d cycles, required 16", busy_cycles);
        end
        n_checks++;
        if (leaks != 0) begin
            n_fail++;
            $display("FAIL resweep_valid: rd_valid high in %0d sweep cycles, required 0", leaks);
        end
        idle();
        bus.rd_en = 1'b1; bus.rd_set = 4'd0;
        step();
        n_checks++;
        if (bus.rd_data !== 3'b000 || bus.rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL resweep_write_ignored: data=%b valid=%b, required 000 valid=1", bus.rd_data, bus.rd_valid);
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        logic [3:0] ws;
        for (int s = 0; s < 16; s++) begin
            mdl[s] = 3'(s) ^ 3'b101;
            bus.wr_en = 1'b1; bus.wr_set = 4'(s); bus.wr_data = mdl[s];
            step();
        end
        idle();
        for (int i = 0; i < 18; i++) begin
            exp = mdl[i % 16];
            ws = 4'((i + 8) % 16);
            bus.rd_en = 1'b1; bus.rd_set = 4'(i % 16);
            bus.wr_en = 1'b1; bus.wr_set = ws; bus.wr_data = ~mdl[ws];
            mdl[ws] = ~mdl[ws];
            step();
            n_checks++;
            if (bus.rd_data !== exp || bus.rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b read %0d set %0d: data=%b valid=%b, required %b valid=1", i, i % 16, bus.rd_data, bus.rd_valid, exp);
            end
        end
        idle();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        test_reset();
        test_basic_rw();
        test_collision();
        test_hold_coherence();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
